// File: rtl/urat_tx_serializer.sv
// UART transmit serializer: accepts a 12-bit frame by valid/ready and shifts it out MSB first.
// Optional build macro URAT_TX_PARITY_CHECK_EN drops even-parity-violating frames and pulses par_err.
module urat_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FRAME_W      = 12,
    parameter logic        IDLE_LVL     = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    output logic               tx,
    output logic               busy,
    output logic               done,
    output logic               par_err
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = 4;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_FIRST = BIT_W'(FRAME_W - 1);

    typedef enum logic {
        st_idle,
        st_shift
    } state_t;

    state_t             state_q, state_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               hs, par_ok, load;
    logic               tx_d, busy_d, done_d, ready_d, par_err_d;

    assign hs = frame_valid && frame_ready;
`ifdef URAT_TX_PARITY_CHECK_EN
    assign par_ok = (frame_in[2] == ^frame_in[10:3]);
`else
    assign par_ok = 1'b1;
`endif
    assign load = hs && par_ok;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath next values
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        case (state_q)
            st_idle: begin
                if (load) begin
                    state_d = st_shift;
                    shift_d = frame_in;
                    baud_d  = '0;
                    bit_d   = BIT_FIRST;
                end
            end
            st_shift: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q != '0) begin
                        shift_d = {shift_q[FRAME_W-2:0], 1'b0};
                        bit_d   = bit_q - BIT_W'(1);
                    end else if (load) begin
                        shift_d = frame_in;
                        bit_d   = BIT_FIRST;
                    end else begin
                        state_d = st_idle;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: state_d = st_idle;
        endcase
    end

    // Output next values, computed from next state so the registered outputs line up
    always_comb begin
        busy_d    = (state_d == st_shift);
        tx_d      = busy_d ? shift_d[FRAME_W-1] : IDLE_LVL;
        done_d    = busy_d && (bit_d == '0) && (baud_d == BAUD_LAST);
        ready_d   = !busy_d || done_d;
        par_err_d = hs && !par_ok;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q     <= '0;
            baud_q      <= '0;
            bit_q       <= '0;
            tx          <= IDLE_LVL;
            busy        <= 1'b0;
            done        <= 1'b0;
            frame_ready <= 1'b0;
            par_err     <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            baud_q      <= baud_d;
            bit_q       <= bit_d;
            tx          <= tx_d;
            busy        <= busy_d;
            done        <= done_d;
            frame_ready <= ready_d;
            par_err     <= par_err_d;
        end
    end

endmodule

// File: tb/tb_urat_tx_serializer.sv
// Directed self-checking bench for urat_tx_serializer with CLKS_PER_BIT=4.
module tb_urat_tx_serializer;

    localparam int unsigned CPB   = 4;
    localparam int unsigned FBITS = 12;
    localparam int unsigned FCYC  = CPB * FBITS;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic        tx;
    logic        busy;
    logic        done;
    logic        par_err;

    int total = 0;
    int bad   = 0;

    localparam logic [11:0] F_A5   = 12'b1_10100101_0_00;
    localparam logic [11:0] F_F0   = 12'b1_11110000_0_00;
    localparam logic [11:0] F_OTH  = 12'b1_01010101_0_00;
    localparam logic [11:0] F_BADP = 12'b1_10100101_1_00;
    localparam logic [11:0] F_GOOD = 12'b1_10100111_1_00;

    urat_tx_serializer #(
        .CLKS_PER_BIT(CPB),
        .FRAME_W     (12),
        .IDLE_LVL    (1'b0)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_in   (frame_in),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .tx         (tx),
        .busy       (busy),
        .done       (done),
        .par_err    (par_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%b exp=%b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_tx"}, tx, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_done"}, done, 1'b0);
        chk({tag, "_ready"}, frame_ready, 1'b1);
    endtask

    // Called in cycle 1 of a frame; checks every cycle through the last one.
    // glitch_at offers a foreign frame for one cycle; rstg_at pulses rst_n between edges.
    task automatic check_frame(input logic [11:0] f, input int glitch_at,
                               input logic [11:0] gf, input int rstg_at);
        logic [11:0] fv;
        fv = f;
        for (int k = 0; k < int'(FCYC); k++) begin
            chk("frm_tx", tx, fv[11 - k / int'(CPB)]);
            chk("frm_busy", busy, 1'b1);
            chk("frm_done", done, k == int'(FCYC) - 1);
            chk("frm_ready", frame_ready, k == int'(FCYC) - 1);
            chk("frm_perr", par_err, 1'b0);
            if (k == glitch_at) begin
                frame_in    = gf;
                frame_valid = 1'b1;
            end else if (k == glitch_at + 1) begin
                frame_valid = 1'b0;
            end
            if (k == rstg_at) begin
                rst_n = 1'b0;
                #2;
                chk("rst_sync_busy", busy, 1'b1);
                chk("rst_sync_ready", frame_ready, 1'b0);
                rst_n = 1'b1;
            end
            if (k != int'(FCYC) - 1) step();
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_in    = '0;
        frame_valid = 1'b0;
        step();
        step();
        chk("rst_tx", tx, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ready", frame_ready, 1'b0);
        chk("rst_perr", par_err, 1'b0);

        rst_n = 1'b1;
        step();
        check_idle("post_rst");

        // Basic single frame
        frame_in    = F_A5;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check_frame(F_A5, -10, F_A5, -10);
        step();
        check_idle("basic_end");

        // Back-to-back with valid held
        frame_in    = F_A5;
        frame_valid = 1'b1;
        step();
        frame_in = F_F0;
        check_frame(F_A5, -10, F_A5, -10);
        step();
        frame_valid = 1'b0;
        check_frame(F_F0, -10, F_F0, -10);
        step();
        check_idle("b2b_end");

        // Foreign valid while busy is ignored
        frame_in    = F_A5;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check_frame(F_A5, 9, F_OTH, -10);
        step();
        check_idle("ign_end");
        step();
        check_idle("ign_end2");

        // Reset mid-frame
        frame_in    = F_A5;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        for (int k = 1; k < 20; k++) step();
        chk("mid_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        step();
        chk("mid_rst_tx", tx, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        chk("mid_rst_ready", frame_ready, 1'b0);
        rst_n = 1'b1;
        step();
        check_idle("mid_rel");
        frame_in    = F_F0;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check_frame(F_F0, -10, F_F0, 5);
        step();
        check_idle("mid_end");

        // Parity handling
        frame_in    = F_BADP;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
`ifdef URAT_TX_PARITY_CHECK_EN
        chk("par_err_pulse", par_err, 1'b1);
        check_idle("par_bad");
        step();
        chk("par_err_clear", par_err, 1'b0);
        check_idle("par_bad2");
        frame_in    = F_GOOD;
        frame_valid = 1'b1;
        step();
        frame_valid = 1'b0;
        check_frame(F_GOOD, -10, F_GOOD, -10);
`else
        chk("par_err_tied", par_err, 1'b0);
        check_frame(F_BADP, -10, F_BADP, -10);
`endif
        step();
        check_idle("par_end");
        chk("par_end_perr", par_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
